// File: rtl/jesd_rx_pkg.sv
// Shared types and helpers for the JESD204B receive code-group-sync logic.
package jesd_rx_pkg;

  typedef enum logic [1:0] {
    CS_INIT  = 2'd0,
    CS_CHECK = 2'd1,
    CS_DATA  = 2'd2
  } cgs_state_t;

  typedef enum logic [1:0] {
    OCT_OTHER   = 2'd0,
    OCT_K       = 2'd1,
    OCT_R       = 2'd2,
    OCT_INVALID = 2'd3
  } octet_class_t;

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K28_0 = 8'h1C;

  // Line errors take priority over the control-character decode.
  function automatic octet_class_t classify_octet(input logic [7:0] octet,
                                                  input logic       is_k,
                                                  input logic       disp_err,
                                                  input logic       not_in_table);
    octet_class_t cls;
    if (disp_err || not_in_table)
      cls = OCT_INVALID;
    else if (is_k && (octet == K28_5))
      cls = OCT_K;
    else if (is_k && (octet == K28_0))
      cls = OCT_R;
    else
      cls = OCT_OTHER;
    return cls;
  endfunction

endpackage

// File: rtl/jesd_rx_cgs_lane.sv
// One lane of code-group synchronisation: walks the octets of a word in
// time order, so several state changes can happen inside a single word.
module jesd_rx_cgs_lane
  import jesd_rx_pkg::*;
#(
  parameter int BYTES_PER_WORD = 4,
  parameter int K_THRESH       = 4,
  parameter int ERR_THRESH     = 3,
  parameter int POS_W          = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        hold,
  input  logic [BYTES_PER_WORD*8-1:0] data,
  input  logic [BYTES_PER_WORD-1:0]   charisk,
  input  logic [BYTES_PER_WORD-1:0]   disp_err,
  input  logic [BYTES_PER_WORD-1:0]   not_in_table,
  output logic [1:0]                  state,
  output logic                        next_init,
  output logic                        ilas_start,
  output logic [POS_W-1:0]            ilas_pos,
  output logic [7:0]                  err_cnt
);

  localparam int KW = $clog2(K_THRESH + 1);
  localparam int EW = $clog2(ERR_THRESH + 1);
  localparam logic [KW-1:0] K_MAX = KW'(K_THRESH);
  localparam logic [EW-1:0] E_MAX = EW'(ERR_THRESH);

  cgs_state_t   state_q, state_d;
  logic [KW-1:0] kcnt_q, kcnt_d;
  logic [EW-1:0] errcnt_q, errcnt_d;
  logic [7:0]    err_cnt_q, err_cnt_d;
  logic          ilas_q, ilas_d;
  logic [POS_W-1:0] pos_q, pos_d;
  octet_class_t  cls;

  // Octet-serial next-state evaluation; a hold overrides the whole word.
  always_comb begin
    state_d   = state_q;
    kcnt_d    = kcnt_q;
    errcnt_d  = errcnt_q;
    err_cnt_d = err_cnt_q;
    ilas_d    = 1'b0;
    pos_d     = '0;
    cls       = OCT_OTHER;
    if (hold) begin
      state_d  = CS_INIT;
      kcnt_d   = '0;
      errcnt_d = '0;
    end else begin
      for (int b = 0; b < BYTES_PER_WORD; b++) begin
        cls = classify_octet(data[8*b +: 8], charisk[b], disp_err[b], not_in_table[b]);
        unique case (state_d)
          CS_INIT: begin
            if (cls == OCT_K) begin
              if (kcnt_d < K_MAX)
                kcnt_d = kcnt_d + 1'b1;
              if (kcnt_d == K_MAX)
                state_d = CS_CHECK;
            end else begin
              kcnt_d = '0;
            end
          end
          CS_CHECK: begin
            if (cls == OCT_R) begin
              state_d  = CS_DATA;
              errcnt_d = '0;
              if (!ilas_d) begin
                ilas_d = 1'b1;
                pos_d  = POS_W'(b);
              end
            end else if (cls != OCT_K) begin
              state_d = CS_INIT;
              kcnt_d  = '0;
            end
          end
          CS_DATA: begin
            if (cls == OCT_INVALID) begin
              if (err_cnt_d != 8'hFF)
                err_cnt_d = err_cnt_d + 8'd1;
              errcnt_d = errcnt_d + 1'b1;
              if (errcnt_d == E_MAX) begin
                state_d  = CS_INIT;
                kcnt_d   = '0;
                errcnt_d = '0;
              end
            end
          end
          default: begin
            state_d = CS_INIT;
            kcnt_d  = '0;
          end
        endcase
      end
    end
  end

  // Lane state, counters and registered ILAS/error outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= CS_INIT;
      kcnt_q    <= '0;
      errcnt_q  <= '0;
      err_cnt_q <= '0;
      ilas_q    <= 1'b0;
      pos_q     <= '0;
    end else begin
      state_q   <= state_d;
      kcnt_q    <= kcnt_d;
      errcnt_q  <= errcnt_d;
      err_cnt_q <= err_cnt_d;
      ilas_q    <= ilas_d;
      pos_q     <= pos_d;
    end
  end

  assign state      = state_q;
  assign next_init  = (state_d == CS_INIT);
  assign ilas_start = ilas_q;
  assign ilas_pos   = pos_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: rtl/jesd_rx_cgs.sv
// Multi-lane JESD204B RX code-group sync: per-lane FSMs plus the link-wide
// SYNC~ request and comma-align enables.
module jesd_rx_cgs
  import jesd_rx_pkg::*;
#(
  parameter int NUM_LANES      = 4,
  parameter int BYTES_PER_WORD = 4,
  parameter int K_THRESH       = 4,
  parameter int ERR_THRESH     = 3
) (
  input  logic                                       rxusrclk2_in,
  input  logic                                       reset_in,
  input  logic                                       gtwiz_reset_rx_done_in,
  input  logic [NUM_LANES-1:0]                       lane_en_in,
  input  logic                                       sync_request_in,
  input  logic [NUM_LANES*BYTES_PER_WORD*8-1:0]      rxdata_in,
  input  logic [NUM_LANES*BYTES_PER_WORD-1:0]        rxctrl0_in,
  input  logic [NUM_LANES*BYTES_PER_WORD-1:0]        rxctrl1_in,
  input  logic [NUM_LANES*BYTES_PER_WORD-1:0]        rxctrl3_in,
  output logic                                       sync_n_out,
  output logic [NUM_LANES-1:0]                       rxcommaalignen_out,
  output logic [2*NUM_LANES-1:0]                     cgs_state_out,
  output logic [NUM_LANES-1:0]                       ilas_start_out,
  output logic [NUM_LANES*$clog2(BYTES_PER_WORD)-1:0] ilas_pos_out,
  output logic [NUM_LANES*8-1:0]                     err_cnt_out
);

  localparam int POS_W = $clog2(BYTES_PER_WORD);
  localparam int WB    = BYTES_PER_WORD * 8;

  logic                 hold_all;
  logic [NUM_LANES-1:0] next_init;

  assign hold_all = sync_request_in | ~gtwiz_reset_rx_done_in;

  genvar i;
  generate
    for (i = 0; i < NUM_LANES; i++) begin : g_lane
      jesd_rx_cgs_lane #(
        .BYTES_PER_WORD(BYTES_PER_WORD),
        .K_THRESH      (K_THRESH),
        .ERR_THRESH    (ERR_THRESH),
        .POS_W         (POS_W)
      ) u_lane (
        .clk         (rxusrclk2_in),
        .rst         (reset_in),
        .hold        (hold_all | ~lane_en_in[i]),
        .data        (rxdata_in[i*WB +: WB]),
        .charisk     (rxctrl0_in[i*BYTES_PER_WORD +: BYTES_PER_WORD]),
        .disp_err    (rxctrl1_in[i*BYTES_PER_WORD +: BYTES_PER_WORD]),
        .not_in_table(rxctrl3_in[i*BYTES_PER_WORD +: BYTES_PER_WORD]),
        .state       (cgs_state_out[2*i +: 2]),
        .next_init   (next_init[i]),
        .ilas_start  (ilas_start_out[i]),
        .ilas_pos    (ilas_pos_out[i*POS_W +: POS_W]),
        .err_cnt     (err_cnt_out[i*8 +: 8])
      );
    end
  endgenerate

  // SYNC~ stays asserted while any enabled lane is heading to INIT or none is enabled.
  always_ff @(posedge rxusrclk2_in or posedge reset_in) begin
    if (reset_in) begin
      sync_n_out         <= 1'b0;
      rxcommaalignen_out <= '1;
    end else begin
      sync_n_out         <= (|lane_en_in) & ~(|(next_init & lane_en_in));
      rxcommaalignen_out <= next_init;
    end
  end

endmodule

// File: tb/tb_jesd_rx_cgs.sv
// Directed self-checking bench for jesd_rx_cgs with default parameters.
module tb_jesd_rx_cgs;

  logic         clk = 1'b0;
  logic         rst;
  logic         rx_done;
  logic [3:0]   lane_en;
  logic         sync_req;
  logic [127:0] rxdata;
  logic [15:0]  ctrl0, ctrl1, ctrl3;
  logic         sync_n;
  logic [3:0]   comma;
  logic [7:0]   state;
  logic [3:0]   ilas;
  logic [7:0]   pos;
  logic [31:0]  errc;

  int errors = 0;
  int checks = 0;

  jesd_rx_cgs dut (
    .rxusrclk2_in          (clk),
    .reset_in              (rst),
    .gtwiz_reset_rx_done_in(rx_done),
    .lane_en_in            (lane_en),
    .sync_request_in       (sync_req),
    .rxdata_in             (rxdata),
    .rxctrl0_in            (ctrl0),
    .rxctrl1_in            (ctrl1),
    .rxctrl3_in            (ctrl3),
    .sync_n_out            (sync_n),
    .rxcommaalignen_out    (comma),
    .cgs_state_out         (state),
    .ilas_start_out        (ilas),
    .ilas_pos_out          (pos),
    .err_cnt_out           (errc)
  );

  // 100 MHz user clock
  initial forever #5 clk = ~clk;

  task automatic applyStimulus(input int lane, input logic [31:0] data, input logic [3:0] k,
                               input logic [3:0] disp, input logic [3:0] nit);
    rxdata[lane*32 +: 32] = data;
    ctrl0[lane*4 +: 4]    = k;
    ctrl1[lane*4 +: 4]    = disp;
    ctrl3[lane*4 +: 4]    = nit;
  endtask

  task automatic allK();
    for (int l = 0; l < 4; l++) applyStimulus(l, 32'hBCBCBCBC, 4'hF, 4'h0, 4'h0);
  endtask

  task automatic nextWord();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
  endtask

  task automatic checkLink(input string tag, input logic [31:0] exp_sync,
                           input logic [31:0] exp_comma, input logic [31:0] exp_state);
    checkOutput({tag, "_sync"},  32'(sync_n), exp_sync);
    checkOutput({tag, "_comma"}, 32'(comma),  exp_comma);
    checkOutput({tag, "_state"}, 32'(state),  exp_state);
  endtask

  initial begin
    rst      = 1'b1;
    rx_done  = 1'b1;
    lane_en  = 4'hF;
    sync_req = 1'b0;
    rxdata   = '0;
    ctrl0    = '0;
    ctrl1    = '0;
    ctrl3    = '0;
    #2;
    checkLink("reset", 32'h0, 32'hF, 32'h00);
    checkOutput("reset_ilas", 32'(ilas), 32'h0);
    checkOutput("reset_pos",  32'(pos),  32'h0);
    checkOutput("reset_err",  errc,      32'h0);
    nextWord();
    rst = 1'b0;

    nextWord();
    checkLink("idle", 32'h0, 32'hF, 32'h00);

    // no lane enabled keeps SYNC~ low even with clean K
    lane_en = 4'h0;
    allK();
    nextWord();
    checkLink("no_lanes", 32'h0, 32'hF, 32'h00);

    // GT reset not done holds every lane
    lane_en = 4'hF;
    rx_done = 1'b0;
    nextWord();
    checkLink("gt_not_done", 32'h0, 32'hF, 32'h00);
    rx_done = 1'b1;

    // four K in word 0 reach the threshold on the first edge
    nextWord();
    checkLink("k_word0", 32'h1, 32'h0, 32'h55);
    nextWord();
    nextWord();
    nextWord();
    checkLink("k_word3", 32'h1, 32'h0, 32'h55);

    sync_req = 1'b1;
    nextWord();
    checkLink("sync_req1", 32'h0, 32'hF, 32'h00);
    sync_req = 1'b0;

    // lane 2 breaks its K run on octet 3
    applyStimulus(2, 32'h00BCBCBC, 4'b0111, 4'h0, 4'h0);
    nextWord();
    checkLink("lane2_late", 32'h0, 32'h4, 32'h45);
    allK();
    nextWord();
    checkLink("lane2_ok", 32'h1, 32'h0, 32'h55);

    // lane 0 /R/ at octet 2, lane 1 /R/ at octet 3
    applyStimulus(0, 32'h001CBCBC, 4'b0111, 4'h0, 4'h0);
    applyStimulus(1, 32'h1CBCBCBC, 4'hF, 4'h0, 4'h0);
    nextWord();
    checkLink("ilas", 32'h1, 32'h0, 32'h5A);
    checkOutput("ilas_start", 32'(ilas), 32'h3);
    checkOutput("ilas_pos",   32'(pos),  32'h0E);
    allK();
    nextWord();
    checkOutput("ilas_pulse_end", 32'(ilas),  32'h0);
    checkOutput("data_hold",      32'(state), 32'h5A);

    // lane 1: two disparity errors, then a third one in the next word
    applyStimulus(1, 32'hBCBCBCBC, 4'hF, 4'b0011, 4'h0);
    nextWord();
    checkOutput("err2_cnt", errc, 32'h0000_0200);
    checkLink("err2", 32'h1, 32'h0, 32'h5A);
    applyStimulus(1, 32'hBCBCBCBC, 4'hF, 4'b0100, 4'h0);
    nextWord();
    checkOutput("err3_cnt", errc, 32'h0000_0300);
    checkLink("err3", 32'h0, 32'h2, 32'h52);
    allK();
    nextWord();
    checkLink("lane1_resync", 32'h1, 32'h0, 32'h56);
    checkOutput("err_persist", errc, 32'h0000_0300);

    // remaining lanes to DATA on octet 0; lane 0 ignores the extra /R/
    for (int l = 0; l < 4; l++) applyStimulus(l, 32'h1C1C1C1C, 4'hF, 4'h0, 4'h0);
    nextWord();
    checkLink("all_data", 32'h1, 32'h0, 32'hAA);
    checkOutput("ilas_all", 32'(ilas), 32'hE);
    checkOutput("pos_all",  32'(pos),  32'h00);

    allK();
    sync_req = 1'b1;
    nextWord();
    checkLink("sync_req2", 32'h0, 32'hF, 32'h00);
    checkOutput("sync_req2_err", errc, 32'h0000_0300);
    sync_req = 1'b0;
    nextWord();
    checkLink("resync", 32'h1, 32'h0, 32'h55);

    // only lanes 0-1 enabled; 2-3 carry garbage
    lane_en = 4'b0011;
    applyStimulus(2, 32'h12345678, 4'h0, 4'b1010, 4'h0);
    applyStimulus(3, 32'h9ABCDEF0, 4'h5, 4'h0, 4'b0001);
    nextWord();
    checkLink("partial_en", 32'h1, 32'hC, 32'h05);

    // asynchronous reset in the middle of a word
    #3;
    rst = 1'b1;
    #1;
    checkLink("async_rst", 32'h0, 32'hF, 32'h00);
    checkOutput("async_rst_ilas", 32'(ilas), 32'h0);
    checkOutput("async_rst_pos",  32'(pos),  32'h0);
    checkOutput("async_rst_err",  errc,      32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jesd_rx_cgs.md
# jesd_rx_cgs

Parametrised multi-lane JESD204B receive code-group-synchronisation block. It sits between the GTY transceiver RX user interface and the JESD204B receive link layer. It runs one CGS state machine per lane on the 8b/10b-decoded octets and drives the link-wide active-low SYNC~ request. It also gates comma realignment and flags the start of the ILAS sequence on each lane.

## Interface
Parameters:
- NUM_LANES, 4, number of JESD lanes (1–8).
- BYTES_PER_WORD, 4, octets per lane per clock (2 or 4); octet 0 in bits [7:0] is first in time.
- K_THRESH, 4, consecutive valid /K/ octets required to leave CS_INIT.
- ERR_THRESH, 3, invalid octets in CS_DATA that force re-sync.

Ports:
- rxusrclk2_in  in  1  RX user clock; all logic on its rising edge.
- reset_in  in  1  asynchronous, active-high reset.
- gtwiz_reset_rx_done_in  in  1  GT RX reset complete; while 0, all lanes are held in CS_INIT.
- lane_en_in  in  NUM_LANES  lane enable; a disabled lane is held in CS_INIT and excluded from SYNC~.
- sync_request_in  in  1  level; while 1, all lanes are forced to CS_INIT.
- rxdata_in  in  NUM_LANES*BYTES_PER_WORD*8  decoded octets, lane-major.
- rxctrl0_in  in  NUM_LANES*BYTES_PER_WORD  charisk per octet.
- rxctrl1_in  in  NUM_LANES*BYTES_PER_WORD  disparity error per octet.
- rxctrl3_in  in  NUM_LANES*BYTES_PER_WORD  not-in-table per octet.
- sync_n_out  out  1  JESD SYNC~, active low.
- rxcommaalignen_out  out  NUM_LANES  comma-align enable per lane, drives m/p comma align.
- cgs_state_out  out  2*NUM_LANES  per-lane state: 0=INIT, 1=CHECK, 2=DATA.
- ilas_start_out  out  NUM_LANES  one-cycle pulse on the first /R/ seen.
- ilas_pos_out  out  NUM_LANES*$clog2(BYTES_PER_WORD)  octet index of that /R/, valid with the pulse.
- err_cnt_out  out  NUM_LANES*8  saturating count of invalid octets in CS_DATA, per lane.

## Operation
- Octet classes:
  - invalid: disparity error or not-in-table.
  - /K/: charisk and 0xBC.
  - /R/: charisk and 0x1C.
  - other: anything else.
- Octets are evaluated in order 0..BYTES_PER_WORD-1 within one cycle. A state change takes effect for the following octets of the same word.
- CS_INIT:
  - /K/ increments kcnt, saturating at K_THRESH.
  - Any other class clears kcnt.
  - kcnt reaching K_THRESH moves the lane to CS_CHECK.
- CS_CHECK:
  - /K/ stays in CS_CHECK.
  - /R/ moves to CS_DATA, fires ilas_start, and records the octet index.
  - invalid or other returns to CS_INIT and clears kcnt.
- CS_DATA:
  - invalid increments errcnt (window) and err_cnt_out (saturating at 255).
  - errcnt reaching ERR_THRESH returns to CS_INIT.
  - errcnt clears on entry to CS_DATA.
- Force conditions (override all of the above, including mid-word): sync_request_in=1, gtwiz_reset_rx_done_in=0, or lane_en_in[i]=0. A forced lane goes to CS_INIT with kcnt=0 and errcnt=0.
- sync_n_out = 0 if any enabled lane's next state is CS_INIT, or no lane is enabled; otherwise 1.
- rxcommaalignen_out[i] = 1 iff lane i's next state is CS_INIT.
- Only the first /R/ per CS_DATA entry pulses ilas_start_out. Later /R/ octets are ignored.

## Timing
- Reset values: all lanes CS_INIT, kcnt=0, errcnt=0, sync_n_out=0, rxcommaalignen_out all 1, ilas_start_out=0, ilas_pos_out=0, err_cnt_out=0.
- All outputs are registered and update on the same edge that samples the word causing the change: one-cycle latency from input to output.
- ilas_start_out is high for exactly one cycle.
- Reset asserted mid-word returns every output to its reset value immediately.
- If a lane goes INIT→CHECK→DATA within one word, the transition is legal and ilas_start pulses on that edge.
- err_cnt_out persists across re-sync. It clears only on reset.

## Structure
- Package jesd_rx_pkg:
  - cgs_state_t enum (CS_INIT, CS_CHECK, CS_DATA).
  - K28_5=8'hBC, K28_0=8'h1C.
  - classify_octet function.
- Sub-module jesd_rx_cgs_lane: one lane FSM with counters, instantiated NUM_LANES times in a generate loop.
- The top level holds the SYNC~ reduction and output registers.

## Test plan
- Reset, then 4 words of 0xBCBCBCBC with charisk=1111 on all 4 lanes (defaults) -> sync_n_out rises on the first word's edge, since kcnt reaches 4 within word 0; all cgs_state=1; rxcommaalignen_out=0000.
- Lane 2 sends BC,BC,BC,00 then BC×4 -> lane 2 stays INIT one extra word; sync_n_out held 0 until that word.
- Lanes in CHECK; lane 0 word = BC,BC,1C,xx with charisk on octets 0–2 -> lane 0 state=2, ilas_start_out[0] one cycle, ilas_pos_out=2.
- Lane 1 in DATA; 3 octets with rxctrl1=1 across two words -> lane 1 returns to INIT, sync_n_out=0, err_cnt_out[1]=3.
- sync_request_in pulsed 1 cycle with all lanes in DATA -> all states 0 and sync_n_out=0 on the next edge; K re-sync resumes normally.
- lane_en_in=0011, lanes 2–3 sending garbage, lanes 0–1 sending /K/ -> sync_n_out=1; asserting reset_in mid-sequence -> all outputs at reset values without waiting for a clock edge.
